// File: rtl/pcileech_bar_req_serializer.sv
// Serialises decoded BAR writes and reads into one in-order stream so that the
// write and read strobes to the BAR implementation are never high together.
`timescale 1ns/1ps
module pcileech_bar_req_serializer #(
    parameter int DEPTH      = 8,
    parameter int RD_CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_wr_addr,
    input  logic [3:0]  in_wr_be,
    input  logic [31:0] in_wr_data,
    input  logic        in_wr_valid,
    input  logic [87:0] in_rd_req_ctx,
    input  logic [31:0] in_rd_req_addr,
    input  logic        in_rd_req_valid,
    output logic        in_ready,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    output logic [87:0] rd_req_ctx,
    output logic [31:0] rd_req_addr,
    output logic        rd_req_valid,
    input  logic        rd_rsp_valid,
    output logic        overflow,
    output logic [3:0]  rd_outstanding
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 121;
    localparam logic [AW:0] READY_MAX  = (AW+1)'(DEPTH - 2);
    localparam logic [3:0]  CREDIT_MAX = 4'(RD_CREDITS);

    // Entry layout: {is_rd, addr[31:0], payload[87:0]}
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_rd;
    logic [AW:0]   count;
    logic [3:0]    credits;

    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    logic [EW-1:0] head_entry;
    logic          any_valid;
    logic          push_wr;
    logic          push_rd;
    logic          head_is_rd;
    logic          pop;
    logic          pop_rd;
    logic          rsp_take;

    assign in_ready       = (count <= READY_MAX);
    assign rd_outstanding = credits;

    always_comb begin
        wr_entry   = {1'b0, in_wr_addr, 52'd0, in_wr_be, in_wr_data};
        rd_entry   = {1'b1, in_rd_req_addr, in_rd_req_ctx};
        any_valid  = in_wr_valid | in_rd_req_valid;
        push_wr    = in_wr_valid & in_ready;
        push_rd    = in_rd_req_valid & in_ready;
        // A simultaneous read lands one slot behind the write so it stays younger.
        tail_rd    = push_wr ? tail + AW'(1) : tail;
        head_entry = mem[head];
        head_is_rd = head_entry[EW-1];
        pop        = (count != '0) && (!head_is_rd || (credits < CREDIT_MAX));
        pop_rd     = pop & head_is_rd;
        rsp_take   = rd_rsp_valid & (credits != '0);
    end

    always_ff @(posedge clk) begin
        if (push_wr) mem[tail]    <= wr_entry;
        if (push_rd) mem[tail_rd] <= rd_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            credits      <= '0;
            overflow     <= 1'b0;
            wr_valid     <= 1'b0;
            rd_req_valid <= 1'b0;
            wr_addr      <= '0;
            wr_be        <= '0;
            wr_data      <= '0;
            rd_req_addr  <= '0;
            rd_req_ctx   <= '0;
        end else begin
            wr_valid     <= pop & ~head_is_rd;
            rd_req_valid <= pop_rd;
            if (pop) begin
                head <= head + AW'(1);
                if (head_is_rd) begin
                    rd_req_addr <= head_entry[119:88];
                    rd_req_ctx  <= head_entry[87:0];
                end else begin
                    wr_addr <= head_entry[119:88];
                    wr_be   <= head_entry[35:32];
                    wr_data <= head_entry[31:0];
                end
            end
            tail  <= tail + AW'(push_wr) + AW'(push_rd);
            count <= count + (AW+1)'(push_wr) + (AW+1)'(push_rd) - (AW+1)'(pop);
            if (pop_rd && !rsp_take)
                credits <= credits + 4'd1;
            else if (rsp_take && !pop_rd)
                credits <= credits - 4'd1;
            if (any_valid && !in_ready)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcileech_bar_req_serializer.sv
// Scoreboard bench: a queue-level reference model predicts every issued request
// and its cycle; a negedge monitor compares DUT outputs against the predictions.
`timescale 1ns/1ps
module tb_pcileech_bar_req_serializer;

    localparam int DEPTH      = 8;
    localparam int RD_CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_wr_addr = '0;
    logic [3:0]  in_wr_be = '0;
    logic [31:0] in_wr_data = '0;
    logic        in_wr_valid = 1'b0;
    logic [87:0] in_rd_req_ctx = '0;
    logic [31:0] in_rd_req_addr = '0;
    logic        in_rd_req_valid = 1'b0;
    logic        in_ready;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic [87:0] rd_req_ctx;
    logic [31:0] rd_req_addr;
    logic        rd_req_valid;
    logic        rd_rsp_valid = 1'b0;
    logic        overflow;
    logic [3:0]  rd_outstanding;

    pcileech_bar_req_serializer #(.DEPTH(DEPTH), .RD_CREDITS(RD_CREDITS)) dut (
        .clk(clk), .rst(rst),
        .in_wr_addr(in_wr_addr), .in_wr_be(in_wr_be), .in_wr_data(in_wr_data),
        .in_wr_valid(in_wr_valid),
        .in_rd_req_ctx(in_rd_req_ctx), .in_rd_req_addr(in_rd_req_addr),
        .in_rd_req_valid(in_rd_req_valid),
        .in_ready(in_ready),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
        .rd_rsp_valid(rd_rsp_valid),
        .overflow(overflow), .rd_outstanding(rd_outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [87:0] ctx;
        int unsigned due;
    } ent_t;

    ent_t        m_q[$];
    ent_t        exp_q[$];
    int unsigned m_cred = 0;
    bit          m_ovf = 0;
    int unsigned edges = 0;
    bit          mon_on = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] last_wa = '0;
    logic [3:0]  last_wbe = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_ra = '0;
    logic [87:0] last_rctx = '0;

    ent_t m_e;
    bit   m_ready;
    bit   m_pop_rd;
    bit   m_rsp;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got=%0h want=%0h", nm, edges, got, want);
        end
    endtask

    task automatic bump_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at edge %0d", nm, edges);
    endtask

    // Reference model: one step per clock edge, in terms of queues and counts.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_cred    = 0;
            m_ovf     = 0;
            last_wa   = '0; last_wbe = '0; last_wd = '0;
            last_ra   = '0; last_rctx = '0;
        end else begin
            m_ready  = (m_q.size() <= DEPTH - 2);
            m_pop_rd = 0;
            if (m_q.size() > 0 && (!m_q[0].is_rd || m_cred < RD_CREDITS)) begin
                m_e      = m_q.pop_front();
                m_e.due  = edges + 1;
                m_pop_rd = m_e.is_rd;
                exp_q.push_back(m_e);
            end
            m_rsp = rd_rsp_valid && (m_cred > 0);
            if (m_pop_rd) m_cred = m_cred + 1;
            if (m_rsp)    m_cred = m_cred - 1;
            if (in_wr_valid || in_rd_req_valid) begin
                if (m_ready) begin
                    if (in_wr_valid) begin
                        m_e = '{0, in_wr_addr, in_wr_be, in_wr_data, '0, 0};
                        m_q.push_back(m_e);
                    end
                    if (in_rd_req_valid) begin
                        m_e = '{1, in_rd_req_addr, '0, '0, in_rd_req_ctx, 0};
                        m_q.push_back(m_e);
                    end
                end else begin
                    m_ovf = 1;
                end
            end
        end
        edges++;
    end

    ent_t mon_e;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("strobe_exclusive", 128'(wr_valid & rd_req_valid), 128'(0));
            chk("in_ready", 128'(in_ready), 128'(m_q.size() <= DEPTH - 2));
            chk("rd_outstanding", 128'(rd_outstanding), 128'(m_cred));
            chk("overflow", 128'(overflow), 128'(m_ovf));
            if (wr_valid || rd_req_valid) begin
                if (exp_q.size() == 0) begin
                    bump_fail("unexpected_issue");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_kind", 128'(rd_req_valid), 128'(mon_e.is_rd));
                    chk("issue_cycle", 128'(edges), 128'(mon_e.due));
                    if (mon_e.is_rd) begin
                        last_ra = mon_e.addr; last_rctx = mon_e.ctx;
                    end else begin
                        last_wa = mon_e.addr; last_wbe = mon_e.be; last_wd = mon_e.data;
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edges) begin
                bump_fail("missed_issue");
                void'(exp_q.pop_front());
            end
            chk("wr_addr", 128'(wr_addr), 128'(last_wa));
            chk("wr_be", 128'(wr_be), 128'(last_wbe));
            chk("wr_data", 128'(wr_data), 128'(last_wd));
            chk("rd_req_addr", 128'(rd_req_addr), 128'(last_ra));
            chk("rd_req_ctx", 128'(rd_req_ctx), 128'(last_rctx));
        end
    end

    task automatic step(input bit wv, input bit rv, input bit rsp);
        in_wr_valid     = wv;
        in_rd_req_valid = rv;
        rd_rsp_valid    = rsp;
        @(posedge clk);
        #1;
        in_wr_valid     = 1'b0;
        in_rd_req_valid = 1'b0;
        rd_rsp_valid    = 1'b0;
    endtask

    task automatic rand_fields();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        in_wr_addr     = $urandom();
        in_wr_be       = 4'($urandom_range(0, 15));
        in_wr_data     = $urandom();
        in_rd_req_addr = $urandom();
        in_rd_req_ctx  = t[87:0];
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1;
        step(0, 0, 0);

        // Single write
        in_wr_addr = 32'h50; in_wr_be = 4'hF; in_wr_data = 32'h0001_0000;
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);

        // Simultaneous write and read
        in_wr_addr = 32'hEC; in_wr_data = 32'h400; in_wr_be = 4'h3;
        in_rd_req_addr = 32'h0C; in_rd_req_ctx = {11{8'hA5}};
        step(1, 1, 0);
        repeat (4) step(0, 0, 0);

        // Credit stall: six reads, one response later
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            step(0, 1, 0);
        end
        repeat (4) step(0, 0, 0);
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);

        // Fill to the in_ready threshold, then push into a full FIFO
        n = 0;
        while (m_q.size() <= DEPTH - 2 && n < 20) begin
            rand_fields();
            step(0, 1, 0);
            n++;
        end
        rand_fields();
        step(0, 1, 0);
        step(1, 1, 0);
        repeat (30) step(0, 0, 1);

        // Reset with a blocked read and writes queued
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            step(0, 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            step(1, 0, 0);
        end
        repeat (2) step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        repeat (4) step(0, 0, 0);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // Randomised traffic with a mid-run reset
        for (int i = 0; i < 800; i++) begin
            rand_fields();
            if (i == 400) begin
                rst = 1'b1;
                step(0, 0, 0);
                rst = 1'b0;
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
        end

        n = 0;
        while ((m_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
            step(0, 0, 1);
            n++;
        end
        if (m_q.size() != 0 || exp_q.size() != 0) bump_fail("drain_timeout");
        repeat (2) step(0, 0, 0);
        mon_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcileech_bar_req_serializer.md
# pcileech_bar_req_serializer

Sits directly upstream of the 1394 BAR implementation. It accepts decoded BAR write and read requests from the TLP/BAR front end and issues them to the BAR implementation one at a time, in arrival order. The BAR implementation handles a read ahead of a write in the same cycle and loses the write; this block guarantees that write and read request strobes are never asserted together. It also limits outstanding reads using a credit count that tracks read responses.

## Interface
- DEPTH, 8: unified request FIFO entries; power of 2, ≥4.
- RD_CREDITS, 4: maximum reads issued but not yet answered; 1..15.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_wr_addr / in_wr_be / in_wr_data  in  32/4/32  incoming BAR write.
- in_wr_valid  in  1  write strobe, one cycle per request.
- in_rd_req_ctx / in_rd_req_addr  in  88/32  incoming BAR read.
- in_rd_req_valid  in  1  read strobe, one cycle per request.
- in_ready  out  1  high when at least 2 FIFO slots are free.
- wr_addr / wr_be / wr_data  out  32/4/32  write request to the BAR implementation.
- wr_valid  out  1  write strobe.
- rd_req_ctx / rd_req_addr  out  88/32  read request to the BAR implementation.
- rd_req_valid  out  1  read strobe.
- rd_rsp_valid  in  1  monitored read-response strobe from the BAR implementation.
- overflow  out  1  sticky; set when a request is dropped.
- rd_outstanding  out  4  reads currently in flight.

## Operation
- FIFO entry: {is_rd, addr[31:0], payload}. For writes, payload = {be, data}, zero-extended. For reads, payload = ctx[87:0].
- Push, when in_ready=1:
  - A write alone pushes 1 entry.
  - A read alone pushes 1 entry.
  - A write and read in the same cycle push 2 entries, write first (the write is older; reads never pass writes).
- Drop: if any in_*valid is high while in_ready=0, every request in that cycle is dropped and overflow is set. Overflow clears only on rst.
- Pop: at most one entry per cycle, strictly from the head.
  - Condition: FIFO not empty, and either the head is a write or rd_outstanding < RD_CREDITS.
  - A blocked read at the head also blocks every entry behind it (head-of-line blocking is intended).
- Issue: a popped entry drives the output registers on the next edge, with exactly one of wr_valid / rd_req_valid high for one cycle.
  - Field outputs hold their last value while the strobes are low.
- Credit counter:
  - +1 when a read is popped; −1 on rd_rsp_valid.
  - Both in the same cycle: unchanged.
  - rd_rsp_valid while the counter is 0 is ignored (saturates at 0).
  - The pop check uses the registered counter, so a response frees a credit for the following cycle, not the same one.
- FIFO count: +pushes − pop each cycle, with 0..2 pushes and 0..1 pop; it never exceeds DEPTH.

## Timing
- Reset values:
  - wr_valid = 0, rd_req_valid = 0.
  - All address, be, data and ctx outputs = 0.
  - overflow = 0, rd_outstanding = 0.
  - FIFO empty, so in_ready = 1 in the first cycle after reset.
- Latency: a request sampled in cycle N into an empty, unblocked FIFO appears on the output strobe in cycle N+2.
- Throughput: one request per cycle at the output. Two simultaneous inputs issue in consecutive cycles.
- in_ready depends only on the registered count (in_ready = count ≤ DEPTH−2). It has no combinational path from the inputs.
- Reset during operation:
  - Queued entries are discarded and never issued.
  - Strobes go low on the reset edge; the counter and overflow clear.
  - A response arriving after reset for a pre-reset read is ignored by saturation.
- Pointers are log2(DEPTH) bits and wrap naturally; full and empty are distinguished by the count, not by pointer equality.

## Test plan
- Single write: in_wr_valid in cycle 0 with addr 0x50, be 0xF, data 0x00010000 -> wr_valid=1 only in cycle 2 with identical fields; rd_req_valid stays 0.
- Simultaneous write and read in cycle 0 (write 0xEC/0x400, read 0x0C, ctx 0xA5…) -> wr_valid in cycle 2, rd_req_valid in cycle 3, never both high in one cycle; rd_req_ctx matches.
- Credit stall: RD_CREDITS=4, six reads in cycles 0–5, no responses:
  - Expect rd_req_valid in cycles 2–5, then rd_outstanding=4 and a stall.
  - rd_rsp_valid in cycle 10 -> 5th read issued in cycle 12, and rd_outstanding returns to 4.
- Full and overflow: DEPTH=8, credits exhausted, keep pushing reads until count=7:
  - Expect in_ready=0.
  - A further read -> dropped, overflow=1, count stays 7.
  - After responses drain the FIFO, overflow stays 1.
- Reset mid-operation: 5 entries queued and rd_outstanding=3; assert rst for 1 cycle:
  - Next cycle: all strobes 0, rd_outstanding=0, in_ready=1, overflow=0.
  - No queued entry is ever issued.
  - A late rd_rsp_valid leaves rd_outstanding=0.
